// File: rtl/eth_tx_arb.sv
// Two-requester round-robin packet arbiter feeding one tx byte stream, with IFG insertion and oversize truncation.
// Optional per-requester completed-packet counters are enabled by defining ETH_TX_ARB_STATS_EN.
module eth_tx_arb #(
  parameter int pIFG_CYCLES    = 48,
  parameter int pMAX_PKT_BYTES = 1518
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [9:0] Req0_Byte,
  input  logic       Req0_Vld,
  output logic       Req0_Rd,
  input  logic [9:0] Req1_Byte,
  input  logic       Req1_Vld,
  output logic       Req1_Rd,
  output logic [9:0] Tx_Byte,
  output logic       Tx_Vld,
  input  logic       Tx_Rdy,
  output logic [1:0] Grant,
  output logic       Err_Drop,
  output logic       Err_Oversize
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [15:0] Pkt_Cnt0,
  output logic [15:0] Pkt_Cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, IFG} state_t;

  localparam logic [10:0] IFG_LOAD = (pIFG_CYCLES > 0) ? 11'(pIFG_CYCLES - 1) : 11'd0;
  localparam logic [10:0] MAX_LAST = 11'(pMAX_PKT_BYTES - 1);
  localparam state_t      END_STATE = (pIFG_CYCLES == 0) ? IDLE : IFG;

  state_t      state, stateNxt;
  logic [10:0] cnt, cntNxt;
  logic        owner, ownerNxt;
  logic        lastSrv, lastSrvNxt;
  logic [9:0]  gByte;
  logic        gVld;
  logic        gRd;
  logic        cand0, cand1;

  assign gByte = owner ? Req1_Byte : Req0_Byte;
  assign gVld  = owner ? Req1_Vld  : Req0_Vld;
  assign gRd   = (state == STREAM) ? (Tx_Rdy & gVld) :
                 (state == FLUSH)  ? gVld : 1'b0;
  assign cand0 = Req0_Vld & Req0_Byte[9];
  assign cand1 = Req1_Vld & Req1_Byte[9];
  assign Grant = ((state == STREAM) || (state == FLUSH)) ? {owner, ~owner} : 2'b00;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= 11'd0;
      owner   <= 1'b0;
      lastSrv <= 1'b1;
    end else begin
      state   <= stateNxt;
      cnt     <= cntNxt;
      owner   <= ownerNxt;
      lastSrv <= lastSrvNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    cntNxt       = cnt;
    ownerNxt     = owner;
    lastSrvNxt   = lastSrv;
    Tx_Byte      = 10'd0;
    Tx_Vld       = 1'b0;
    Req0_Rd      = 1'b0;
    Req1_Rd      = 1'b0;
    Err_Drop     = 1'b0;
    Err_Oversize = 1'b0;
    case (state)
      IDLE: begin
        // Non-SOP bytes are popped and thrown away; SOP bytes wait to be streamed.
        Req0_Rd  = Req0_Vld & ~Req0_Byte[9];
        Req1_Rd  = Req1_Vld & ~Req1_Byte[9];
        Err_Drop = Req0_Rd | Req1_Rd;
        if (cand0 && cand1) ownerNxt = ~lastSrv;
        else if (cand0)     ownerNxt = 1'b0;
        else if (cand1)     ownerNxt = 1'b1;
        if (cand0 || cand1) begin
          stateNxt   = STREAM;
          lastSrvNxt = ownerNxt;
          cntNxt     = 11'd0;
        end
      end
      STREAM: begin
        Tx_Byte = gByte;
        Tx_Vld  = gVld;
        // The last permitted byte carries a forced EOP so downstream closes the frame.
        if (cnt == MAX_LAST) Tx_Byte[8] = 1'b1;
        Req0_Rd = gRd & ~owner;
        Req1_Rd = gRd & owner;
        if (gRd) begin
          cntNxt = cnt + 11'd1;
          if (gByte[8]) begin
            stateNxt = END_STATE;
            cntNxt   = IFG_LOAD;
          end else if (cnt == MAX_LAST) begin
            Err_Oversize = 1'b1;
            stateNxt     = FLUSH;
          end
        end
      end
      FLUSH: begin
        Req0_Rd = gRd & ~owner;
        Req1_Rd = gRd & owner;
        if (gVld && gByte[8]) begin
          stateNxt = END_STATE;
          cntNxt   = IFG_LOAD;
        end
      end
      IFG: begin
        cntNxt = cnt - 11'd1;
        if (cnt == 11'd0) begin
          stateNxt = IDLE;
          cntNxt   = 11'd0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic pktDone;

  // A packet counts once: at its EOP transfer or at the truncating transfer.
  assign pktDone = (state == STREAM) && gRd && (gByte[8] || (cnt == MAX_LAST));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Pkt_Cnt0 <= 16'd0;
      Pkt_Cnt1 <= 16'd0;
    end else if (pktDone) begin
      if (owner) Pkt_Cnt1 <= Pkt_Cnt1 + 16'd1;
      else       Pkt_Cnt0 <= Pkt_Cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed self-checking bench for eth_tx_arb: a default-parameter instance and a small
// instance (4-byte max, 2-cycle IFG) share stimulus; stats checks need ETH_TX_ARB_STATS_EN.
module tb_eth_tx_arb;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [9:0] r0b = 10'd0, r1b = 10'd0;
  logic       r0v = 1'b0, r1v = 1'b0, txRdy = 1'b0;

  logic       aR0Rd, aR1Rd, aTxVld, aDrop, aOvs;
  logic [9:0] aTxByte;
  logic [1:0] aGrant;
  logic       bR0Rd, bR1Rd, bTxVld, bDrop, bOvs;
  logic [9:0] bTxByte;
  logic [1:0] bGrant;
`ifdef ETH_TX_ARB_STATS_EN
  logic [15:0] aCnt0, aCnt1, bCnt0, bCnt1;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  always #5 Clk = ~Clk;

  eth_tx_arb dutA (
    .Clk(Clk), .Rst(Rst),
    .Req0_Byte(r0b), .Req0_Vld(r0v), .Req0_Rd(aR0Rd),
    .Req1_Byte(r1b), .Req1_Vld(r1v), .Req1_Rd(aR1Rd),
    .Tx_Byte(aTxByte), .Tx_Vld(aTxVld), .Tx_Rdy(txRdy),
    .Grant(aGrant), .Err_Drop(aDrop), .Err_Oversize(aOvs)
`ifdef ETH_TX_ARB_STATS_EN
    , .Pkt_Cnt0(aCnt0), .Pkt_Cnt1(aCnt1)
`endif
  );

  eth_tx_arb #(.pIFG_CYCLES(2), .pMAX_PKT_BYTES(4)) dutB (
    .Clk(Clk), .Rst(Rst),
    .Req0_Byte(r0b), .Req0_Vld(r0v), .Req0_Rd(bR0Rd),
    .Req1_Byte(r1b), .Req1_Vld(r1v), .Req1_Rd(bR1Rd),
    .Tx_Byte(bTxByte), .Tx_Vld(bTxVld), .Tx_Rdy(txRdy),
    .Grant(bGrant), .Err_Drop(bDrop), .Err_Oversize(bOvs)
`ifdef ETH_TX_ARB_STATS_EN
    , .Pkt_Cnt0(bCnt0), .Pkt_Cnt1(bCnt1)
`endif
  );

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; r0v = 1'b0; r1v = 1'b0;
    next();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; r0v = 1'b0; r1v = 1'b0; txRdy = 1'b0;
    next(); next();
    @(negedge Clk);
    totalCnt++; if (aGrant !== 2'b00) $display("FAIL reset_grant: got %b want 00", aGrant); else passCnt++;
    totalCnt++; if (aTxVld !== 1'b0) $display("FAIL reset_txvld: got %b want 0", aTxVld); else passCnt++;
    totalCnt++; if (aTxByte !== 10'h000) $display("FAIL reset_txbyte: got %h want 000", aTxByte); else passCnt++;
    totalCnt++; if (aR0Rd !== 1'b0) $display("FAIL reset_rd0: got %b want 0", aR0Rd); else passCnt++;
    totalCnt++; if (aR1Rd !== 1'b0) $display("FAIL reset_rd1: got %b want 0", aR1Rd); else passCnt++;
    totalCnt++; if (aDrop !== 1'b0) $display("FAIL reset_drop: got %b want 0", aDrop); else passCnt++;
    totalCnt++; if (aOvs !== 1'b0) $display("FAIL reset_ovs: got %b want 0", aOvs); else passCnt++;
`ifdef ETH_TX_ARB_STATS_EN
    totalCnt++; if (aCnt0 !== 16'd0 || aCnt1 !== 16'd0) $display("FAIL reset_stats: got %0d/%0d want 0/0", aCnt0, aCnt1); else passCnt++;
`endif
    next();
    Rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    bit bad;
    do_reset();
    txRdy = 1'b1;
    r0b = 10'h311; r0v = 1'b1;
    r1b = 10'h322; r1v = 1'b1;
    @(negedge Clk);
    totalCnt++; if (aGrant !== 2'b00) $display("FAIL rr_idle_grant: got %b want 00", aGrant); else passCnt++;
    totalCnt++; if (aR0Rd !== 1'b0 || aR1Rd !== 1'b0) $display("FAIL rr_idle_rd: got %b%b want 00", aR1Rd, aR0Rd); else passCnt++;
    next();
    @(negedge Clk);
    totalCnt++; if (aGrant !== 2'b01) $display("FAIL rr_first_grant: got %b want 01", aGrant); else passCnt++;
    totalCnt++; if (aTxByte !== 10'h311) $display("FAIL rr_first_byte: got %h want 311", aTxByte); else passCnt++;
    totalCnt++; if (aR0Rd !== 1'b1) $display("FAIL rr_first_rd0: got %b want 1", aR0Rd); else passCnt++;
    next();
    r0v = 1'b0;
    n = 0; bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (aGrant !== 2'b00) break;
      if (aTxVld !== 1'b0 || aR1Rd !== 1'b0) bad = 1'b1;
      n++;
    end
    // 48 IFG clocks plus the one IDLE clock that issues the grant
    totalCnt++; if (n != 49) $display("FAIL rr_gap_len: got %0d want 49", n); else passCnt++;
    totalCnt++; if (bad) $display("FAIL rr_gap_quiet: got activity want none"); else passCnt++;
    totalCnt++; if (aGrant !== 2'b10) $display("FAIL rr_second_grant: got %b want 10", aGrant); else passCnt++;
    totalCnt++; if (aTxByte !== 10'h322) $display("FAIL rr_second_byte: got %h want 322", aTxByte); else passCnt++;
    next();
    r1v = 1'b0;
  endtask

  task automatic test_rdy_toggle();
    logic [9:0] pkt [3];
    int idx, n;
    bit bad;
    pkt[0] = 10'h2AA; pkt[1] = 10'h0BB; pkt[2] = 10'h1CC;
    do_reset();
    txRdy = 1'b0;
    r0b = pkt[0]; r0v = 1'b1;
    @(negedge Clk);
    totalCnt++; if (aGrant !== 2'b00 || aR0Rd !== 1'b0) $display("FAIL tog_idle: got grant %b rd %b want 00 0", aGrant, aR0Rd); else passCnt++;
    next();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      txRdy = (c % 2 == 0);
      r0b = pkt[idx];
      @(negedge Clk);
      totalCnt++; if (aTxVld !== 1'b1) $display("FAIL tog_vld%0d: got %b want 1", c, aTxVld); else passCnt++;
      totalCnt++; if (aTxByte !== pkt[idx]) $display("FAIL tog_byte%0d: got %h want %h", c, aTxByte, pkt[idx]); else passCnt++;
      totalCnt++; if (aR0Rd !== txRdy) $display("FAIL tog_rd%0d: got %b want %b", c, aR0Rd, txRdy); else passCnt++;
      totalCnt++; if (aGrant !== 2'b01) $display("FAIL tog_grant%0d: got %b want 01", c, aGrant); else passCnt++;
      if (txRdy) idx++;
      next();
    end
    txRdy = 1'b1;
    r0b = 10'h2DD;
    n = 0; bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (aGrant !== 2'b00) break;
      if (aTxVld !== 1'b0 || aR0Rd !== 1'b0) bad = 1'b1;
      n++;
    end
    totalCnt++; if (n != 49) $display("FAIL tog_gap_len: got %0d want 49", n); else passCnt++;
    totalCnt++; if (bad) $display("FAIL tog_gap_quiet: got activity want none"); else passCnt++;
    next();
    r0v = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    r1b = 10'h055; r1v = 1'b1;
    @(negedge Clk);
    totalCnt++; if (aR1Rd !== 1'b1) $display("FAIL drop_rd1: got %b want 1", aR1Rd); else passCnt++;
    totalCnt++; if (aDrop !== 1'b1) $display("FAIL drop_pulse: got %b want 1", aDrop); else passCnt++;
    totalCnt++; if (aTxVld !== 1'b0 || aGrant !== 2'b00) $display("FAIL drop_idle: got vld %b grant %b want 0 00", aTxVld, aGrant); else passCnt++;
    next();
    r1v = 1'b0;
    @(negedge Clk);
    totalCnt++; if (aDrop !== 1'b0 || aR1Rd !== 1'b0) $display("FAIL drop_end: got drop %b rd %b want 0 0", aDrop, aR1Rd); else passCnt++;
    next();
    r0b = 10'h012; r0v = 1'b1;
    r1b = 10'h134; r1v = 1'b1;
    @(negedge Clk);
    totalCnt++; if (aR0Rd !== 1'b1 || aR1Rd !== 1'b1) $display("FAIL drop_both_rd: got %b%b want 11", aR1Rd, aR0Rd); else passCnt++;
    totalCnt++; if (aDrop !== 1'b1) $display("FAIL drop_both_pulse: got %b want 1", aDrop); else passCnt++;
    next();
    r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic test_oversize();
    logic [9:0] pkt [6];
    logic [9:0] expByte;
    logic expVld, expOvs;
    pkt[0] = 10'h201; pkt[1] = 10'h002; pkt[2] = 10'h003;
    pkt[3] = 10'h004; pkt[4] = 10'h005; pkt[5] = 10'h106;
    do_reset();
    txRdy = 1'b1;
    r0b = pkt[0]; r0v = 1'b1;
    @(negedge Clk);
    totalCnt++; if (bGrant !== 2'b00 || bR0Rd !== 1'b0) $display("FAIL ovs_idle: got grant %b rd %b want 00 0", bGrant, bR0Rd); else passCnt++;
    next();
    for (int i = 0; i < 6; i++) begin
      r0b = pkt[i];
      expVld  = (i < 4);
      expByte = (i < 3) ? pkt[i] : (i == 3) ? (pkt[i] | 10'h100) : 10'h000;
      expOvs  = (i == 3);
      @(negedge Clk);
      totalCnt++; if (bTxVld !== expVld) $display("FAIL ovs_vld%0d: got %b want %b", i, bTxVld, expVld); else passCnt++;
      totalCnt++; if (bTxByte !== expByte) $display("FAIL ovs_byte%0d: got %h want %h", i, bTxByte, expByte); else passCnt++;
      totalCnt++; if (bOvs !== expOvs) $display("FAIL ovs_pulse%0d: got %b want %b", i, bOvs, expOvs); else passCnt++;
      totalCnt++; if (bR0Rd !== 1'b1) $display("FAIL ovs_rd%0d: got %b want 1", i, bR0Rd); else passCnt++;
      totalCnt++; if (bGrant !== 2'b01 || bDrop !== 1'b0) $display("FAIL ovs_grant%0d: got grant %b drop %b want 01 0", i, bGrant, bDrop); else passCnt++;
      next();
    end
    r0v = 1'b0;
    @(negedge Clk);
    totalCnt++; if (bGrant !== 2'b00 || bTxVld !== 1'b0) $display("FAIL ovs_ifg: got grant %b vld %b want 00 0", bGrant, bTxVld); else passCnt++;
    next();
  endtask

  task automatic test_reset_mid();
    do_reset();
    txRdy = 1'b1;
    r0b = 10'h2A1; r0v = 1'b1;
    next();
    @(negedge Clk);
    totalCnt++; if (aTxByte !== 10'h2A1) $display("FAIL rstmid_sop: got %h want 2A1", aTxByte); else passCnt++;
    next();
    r0b = 10'h0A2; Rst = 1'b1;
    next();
    Rst = 1'b0; r0v = 1'b0;
    r1b = 10'h2B1; r1v = 1'b1;
    @(negedge Clk);
    totalCnt++; if (aGrant !== 2'b00) $display("FAIL rstmid_grant: got %b want 00", aGrant); else passCnt++;
    totalCnt++; if (aTxVld !== 1'b0 || aTxByte !== 10'h000) $display("FAIL rstmid_tx: got vld %b byte %h want 0 000", aTxVld, aTxByte); else passCnt++;
    totalCnt++; if (aR0Rd !== 1'b0 || aR1Rd !== 1'b0) $display("FAIL rstmid_rd: got %b%b want 00", aR1Rd, aR0Rd); else passCnt++;
    next();
    @(negedge Clk);
    totalCnt++; if (aGrant !== 2'b10) $display("FAIL rstmid_regrant: got %b want 10", aGrant); else passCnt++;
    totalCnt++; if (aTxByte !== 10'h2B1) $display("FAIL rstmid_byte: got %h want 2B1", aTxByte); else passCnt++;
    next();
    r1v = 1'b0;
  endtask

`ifdef ETH_TX_ARB_STATS_EN
  task automatic send_b(input bit sel, input logic [9:0] b);
    bit done;
    if (sel) begin r1b = b; r1v = 1'b1; end
    else begin r0b = b; r0v = 1'b1; end
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if ((sel ? bR1Rd : bR0Rd) === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    next();
    r0v = 1'b0; r1v = 1'b0;
    repeat (4) next();
    totalCnt++; if (!done) $display("FAIL stats_send: got no pop want pop"); else passCnt++;
  endtask

  task automatic test_stats();
    do_reset();
    txRdy = 1'b1;
    totalCnt++; if (bCnt0 !== 16'd0 || bCnt1 !== 16'd0) $display("FAIL stats_zero: got %0d/%0d want 0/0", bCnt0, bCnt1); else passCnt++;
    send_b(1'b0, 10'h301);
    send_b(1'b0, 10'h302);
    send_b(1'b1, 10'h3F0);
    send_b(1'b0, 10'h303);
    @(negedge Clk);
    totalCnt++; if (bCnt0 !== 16'd3) $display("FAIL stats_cnt0: got %0d want 3", bCnt0); else passCnt++;
    totalCnt++; if (bCnt1 !== 16'd1) $display("FAIL stats_cnt1: got %0d want 1", bCnt1); else passCnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_rdy_toggle();
    test_drop();
    test_oversize();
    test_reset_mid();
`ifdef ETH_TX_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
